alu_add_arb: RTL and testbench
==============================

ALU_ADD_ARB -- requirements
Module: alu_add_arb

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  operation accepted this cycle (valid & ready).
REQ-006 req0_op / req1_op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-008 rsp_valid  output  1  result held on rsp_* outputs.
REQ-009 rsp_ready  input  1  consumer takes result (rsp_valid & rsp_ready).
REQ-010 rsp_id  output  1  requester that owns the result.
REQ-011 rsp_s  output  32  sum/difference.
REQ-012 rsp_c, rsp_v, rsp_n, rsp_z  output  1 each  carry-out, signed overflow, sign, zero.

Function
REQ-013 The block SHALL instantiate exactly one cla32_ov adder and share it between both requesters.
REQ-014 FSM states: IDLE, CALC, RESP.
REQ-015 IDLE: if any req valid, grant one, register op/a/b/id, assert that req*_ready for that cycle only, go to CALC; else stay.
REQ-016 Arbitration: round-robin; priority pointer starts at requester 0 and moves to the non-granted requester after each grant; with one valid, that one wins regardless of pointer.
REQ-017 Only in IDLE SHALL any req*_ready be 1; at most one req*_ready high per cycle.
REQ-018 CALC: adder inputs a, (op ? ~b : b), ci = op; register s, co, co_prev into rsp_*; go to RESP.
REQ-019 Flags: rsp_c = co; rsp_v = co XOR co_prev; rsp_n = rsp_s[31]; rsp_z = (rsp_s == 0).
REQ-020 Subtract carry: rsp_c = 1 means no borrow (a >= b unsigned).
REQ-021 RESP: rsp_valid = 1, all rsp_* stable; on rsp_ready go to IDLE; otherwise hold indefinitely.
REQ-022 Latency: grant at edge N, rsp_valid high after edge N+2; minimum issue interval 3 cycles with rsp_ready tied high.
REQ-023 Requests arriving or dropping while not in IDLE SHALL be ignored; no queuing.
REQ-024 rsp_valid SHALL be 0 in IDLE and CALC.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, pointer to 0, rsp_valid = 0, req*_ready = 0, rsp_s = 0, rsp_id = 0, all flags 0.
REQ-026 Reset during CALC or RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-027 Reset release is taken on a clock edge; the first grant may occur at the first edge after release.

Configuration
REQ-028 Macro ALU_ADD_ARB_SAT_EN: when defined, on rsp_v = 1 rsp_s SHALL saturate to 32'h7FFF_FFFF (result sign should be positive, i.e. a[31] = 0) or 32'h8000_0000 (a[31] = 1); rsp_c, rsp_v unchanged; rsp_n, rsp_z derived from the saturated value.
REQ-029 Without ALU_ADD_ARB_SAT_EN, rsp_s SHALL be the wrapped modulo-2^32 result.

Verification
REQ-030 req0 add 0x7FFF_FFFF + 1, rsp_ready = 1 -> rsp_id 0, rsp_s 0x8000_0000, v 1, n 1, c 0, z 0 (SAT_EN: rsp_s 0x7FFF_FFFF, n 0).
REQ-031 req1 sub 5 - 5 -> rsp_s 0, z 1, c 1, v 0, rsp_valid exactly 2 cycles after grant.
REQ-032 Both valid continuously, four ops -> grants ordered 0,1,0,1; never two ready in one cycle.
REQ-033 req0 add 0xFFFF_FFFF + 1 with rsp_ready low 5 cycles -> rsp_s 0, c 1, z 1 held stable 5 cycles; req1_ready stays 0; IDLE after rsp_ready.
REQ-034 req1 sub 0x8000_0000 - 1 -> rsp_s 0x7FFF_FFFF, v 1, c 1 (SAT_EN: 0x8000_0000, n 1).
REQ-035 reset_n pulsed low during CALC -> rsp_valid never asserts for that op; outputs zero; next request is serviced normally with pointer at 0.

Source files
------------

// File: rtl/alu_add_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_add_arb (with helper cla32_ov)
// Brief    : Two-requester round-robin arbiter sharing one 32-bit CLA
//            add/subtract unit, with NZCV flags and a held response.
//            Optional macro ALU_ADD_ARB_SAT_EN saturates on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================

module cla32_ov (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_ci,
    output logic [31:0] o_s,
    output logic        o_co,
    output logic        o_co_prev
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    assign w_g    = i_a & i_b;
    assign w_p    = i_a ^ i_b;
    assign w_c[0] = i_ci;

    // 4-bit lookahead groups; group carries chain between groups
    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        localparam int c_B = 4 * gi;
        logic w_gg;
        logic w_pg;

        assign w_c[c_B+1] = w_g[c_B] | (w_p[c_B] & w_c[c_B]);
        assign w_c[c_B+2] = w_g[c_B+1] | (w_p[c_B+1] & w_g[c_B])
                          | (w_p[c_B+1] & w_p[c_B] & w_c[c_B]);
        assign w_c[c_B+3] = w_g[c_B+2] | (w_p[c_B+2] & w_g[c_B+1])
                          | (w_p[c_B+2] & w_p[c_B+1] & w_g[c_B])
                          | (w_p[c_B+2] & w_p[c_B+1] & w_p[c_B] & w_c[c_B]);
        assign w_gg = w_g[c_B+3] | (w_p[c_B+3] & w_g[c_B+2])
                    | (w_p[c_B+3] & w_p[c_B+2] & w_g[c_B+1])
                    | (w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_g[c_B]);
        assign w_pg = &w_p[c_B+3:c_B];
        assign w_c[c_B+4] = w_gg | (w_pg & w_c[c_B]);
    end

    assign o_s       = w_p ^ w_c[31:0];
    assign o_co      = w_c[32];
    assign o_co_prev = w_c[31];

endmodule

module alu_add_arb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_s,
    output logic        rsp_c,
    output logic        rsp_v,
    output logic        rsp_n,
    output logic        rsp_z
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_ptr;
    logic        r_id;
    logic        r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        w_gnt0;
    logic        w_gnt1;

    logic [31:0] r_rsp_s;
    logic        r_rsp_id;
    logic        r_rsp_c;
    logic        r_rsp_v;
    logic        r_rsp_n;
    logic        r_rsp_z;

    logic [31:0] w_sum;
    logic        w_co;
    logic        w_co_prev;
    logic        w_ovf;
    logic [31:0] w_s_fin;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            c_IDLE: begin
                // a lone requester wins regardless of the pointer
                w_gnt0 = req0_valid & (~req1_valid | ~r_ptr);
                w_gnt1 = req1_valid & ~(req0_valid & (~req1_valid | ~r_ptr));
                if (req0_valid | req1_valid) begin
                    w_state_nxt = c_CALC;
                end
            end
            c_CALC: w_state_nxt = c_RESP;
            c_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    cla32_ov u_cla (
        .i_a       (r_a),
        .i_b       (r_op ? ~r_b : r_b),
        .i_ci      (r_op),
        .o_s       (w_sum),
        .o_co      (w_co),
        .o_co_prev (w_co_prev)
    );

    assign w_ovf = w_co ^ w_co_prev;

    always_comb begin
        w_s_fin = w_sum;
`ifdef ALU_ADD_ARB_SAT_EN
        if (w_ovf) begin
            w_s_fin = r_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_ptr    <= 1'b0;
            r_id     <= 1'b0;
            r_op     <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rsp_s  <= 32'd0;
            r_rsp_id <= 1'b0;
            r_rsp_c  <= 1'b0;
            r_rsp_v  <= 1'b0;
            r_rsp_n  <= 1'b0;
            r_rsp_z  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0 | w_gnt1) begin
                r_ptr <= w_gnt0;
                r_id  <= w_gnt1;
                r_op  <= w_gnt1 ? req1_op : req0_op;
                r_a   <= w_gnt1 ? req1_a  : req0_a;
                r_b   <= w_gnt1 ? req1_b  : req0_b;
            end
            if (r_state == c_CALC) begin
                r_rsp_s  <= w_s_fin;
                r_rsp_id <= r_id;
                r_rsp_c  <= w_co;
                r_rsp_v  <= w_ovf;
                r_rsp_n  <= w_s_fin[31];
                r_rsp_z  <= (w_s_fin == 32'd0);
            end
        end
    end

    // gated so a pending request cannot be acknowledged while reset is held
    assign req0_ready = w_gnt0 & reset_n;
    assign req1_ready = w_gnt1 & reset_n;
    assign rsp_valid  = (r_state == c_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_s      = r_rsp_s;
    assign rsp_c      = r_rsp_c;
    assign rsp_v      = r_rsp_v;
    assign rsp_n      = r_rsp_n;
    assign rsp_z      = r_rsp_z;

endmodule

`default_nettype wire

// File: tb/tb_alu_add_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_add_arb
// Brief    : Directed self-checking bench for alu_add_arb (arbitration,
//            flags, backpressure, async reset; honours ALU_ADD_ARB_SAT_EN).
// Revision : 1.0 - initial release
// ============================================================================

module tb_alu_add_arb;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_s;
    logic        rsp_c, rsp_v, rsp_n, rsp_z;

    int n_checks = 0;
    int n_fail   = 0;

    alu_add_arb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_s      (rsp_s),
        .rsp_c      (rsp_c),
        .rsp_v      (rsp_v),
        .rsp_n      (rsp_n),
        .rsp_z      (rsp_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] s,
                             input logic c, input logic v, input logic n, input logic z);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"},    32'(rsp_id),    32'(id));
        check({tag, "_s"},     rsp_s,          s);
        check({tag, "_c"},     32'(rsp_c),     32'(c));
        check({tag, "_v"},     32'(rsp_v),     32'(v));
        check({tag, "_n"},     32'(rsp_n),     32'(n));
        check({tag, "_z"},     32'(rsp_z),     32'(z));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(rsp_valid),  32'd0);
        check({tag, "_rdy0"},  32'(req0_ready), 32'd0);
        check({tag, "_rdy1"},  32'(req1_ready), 32'd0);
        check({tag, "_s"},     rsp_s,           32'd0);
        check({tag, "_id"},    32'(rsp_id),     32'd0);
        check({tag, "_flags"}, 32'({rsp_c, rsp_v, rsp_n, rsp_z}), 32'd0);
    endtask

    // Single request from one requester with rsp_ready high; starts and ends in IDLE.
    task automatic single_op(input string tag, input logic id, input logic op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] s, input logic c, input logic v,
                             input logic n, input logic z);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        check({tag, "_grant0"}, 32'(req0_ready), 32'(id == 1'b0));
        check({tag, "_grant1"}, 32'(req1_ready), 32'(id == 1'b1));
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check({tag, "_calc_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_calc_rdy"},   32'(req0_ready | req1_ready), 32'd0);
        tick();
        check_rsp(tag, id, s, c, v, n, z);
        tick();
        check({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b0; req0_op = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_a = '0; req1_b = '0;

        tick();
        tick();
        check_zero_outputs("reset");
        reset_n = 1'b1;

        // signed overflow on add
`ifdef ALU_ADD_ARB_SAT_EN
        single_op("ovf_add", 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1,
                  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        single_op("ovf_add", 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1,
                  32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        // zero result, no borrow
        single_op("sub_eq", 1'b1, 1'b1, 32'd5, 32'd5,
                  32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        // signed overflow on subtract
`ifdef ALU_ADD_ARB_SAT_EN
        single_op("ovf_sub", 1'b1, 1'b1, 32'h8000_0000, 32'd1,
                  32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
`else
        single_op("ovf_sub", 1'b1, 1'b1, 32'h8000_0000, 32'd1,
                  32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        // round-robin with both requesters continuously valid; pointer is at 0
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'd1;  req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'd10; req1_b = 32'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant0", 32'(req0_ready), 32'(k % 2 == 0));
            check("rr_grant1", 32'(req1_ready), 32'(k % 2 == 1));
            tick();
            check("rr_calc_rdy", 32'(req0_ready | req1_ready), 32'd0);
            tick();
            check("rr_resp_rdy", 32'(req0_ready | req1_ready), 32'd0);
            check("rr_id", 32'(rsp_id), 32'(k % 2));
            check("rr_s", rsp_s, (k % 2 == 0) ? 32'd3 : 32'd7);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // backpressure: response held while rsp_ready is low; req1 must be ignored
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
        #1;
        check("bp_grant0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'd3; req1_b = 32'd5;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_rsp("bp_hold", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
            check("bp_rdy1", 32'(req1_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_still_resp", 32'(rsp_valid), 32'd1);
        tick();
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        check("bp_idle_grant1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        check_rsp("neg_sub", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // reset during CALC discards the op and resets the pointer
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'd100; req0_b = 32'd23;
        tick();
        req0_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("rst_calc");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_hold_valid", 32'(rsp_valid), 32'd0);
        end
        reset_n = 1'b1;
        tick();
        check("rst_after_valid", 32'(rsp_valid), 32'd0);
        req0_valid = 1'b1; req0_op = 1'b1; req0_a = 32'd9; req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 32'd1; req1_b = 32'd1;
        #1;
        check("rst_ptr_grant0", 32'(req0_ready), 32'd1);
        check("rst_ptr_grant1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check_rsp("post_rst", 1'b0, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
